// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 4-point FFT datapath: the frame loader, the FFT
// stage and the output serializer all import this package.
//   N_PTS / LOG2_N : points per frame and the matching index width
//   cplx_t         : one signed complex sample
//   frame_t        : one frame of N_PTS complex samples
//   bitrev2        : 2-bit bit reversal, maps natural index to butterfly slot
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int N_PTS  = 4;
    localparam int LOG2_N = 2;
    localparam int CPLX_W = 8;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    typedef cplx_t frame_t [N_PTS];

    function automatic logic [LOG2_N-1:0] bitrev2(input logic [LOG2_N-1:0] k);
        return {k[0], k[1]};
    endfunction

endpackage

// File: rtl/fft4_frame_loader_if.sv
// ---------------------------------------------------------------------------
// fft4_frame_loader_if
// Bundles the serial sample input, the parallel frame output and the error
// pulses of the frame loader.
//   master : the environment side (drives samples, consumes frames)
//   slave  : the loader side
// ---------------------------------------------------------------------------
interface fft4_frame_loader_if #(
    parameter int DATA_W = 8
);
    import fft_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_r;
    logic signed [DATA_W-1:0] in_i;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_r [N_PTS];
    logic signed [DATA_W-1:0] out_i [N_PTS];
    logic                     err_short;
    logic                     err_long;

    modport master (
        output in_valid, in_r, in_i, in_last, out_ready,
        input  in_ready, out_valid, out_r, out_i, err_short, err_long
    );

    modport slave (
        input  in_valid, in_r, in_i, in_last, out_ready,
        output in_ready, out_valid, out_r, out_i, err_short, err_long
    );

endinterface

// File: rtl/fft4_frame_bank.sv
// ---------------------------------------------------------------------------
// fft4_frame_bank
// One 4-slot complex sample store. A single slot is written per cycle when
// we is high; all slots are read in parallel. Contents clear on reset.
//   clk, rst_n   : clock, asynchronous active-low reset
//   we, slot     : write enable and target slot
//   wr_r, wr_i   : sample to write
//   rd_r, rd_i   : all stored slots, slot 0..3
// ---------------------------------------------------------------------------
module fft4_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [LOG2_N-1:0]        slot,
    input  logic signed [DATA_W-1:0] wr_r,
    input  logic signed [DATA_W-1:0] wr_i,
    output logic signed [DATA_W-1:0] rd_r [N_PTS],
    output logic signed [DATA_W-1:0] rd_i [N_PTS]
);

    logic signed [DATA_W-1:0] re_q [N_PTS];
    logic signed [DATA_W-1:0] re_d [N_PTS];
    logic signed [DATA_W-1:0] im_q [N_PTS];
    logic signed [DATA_W-1:0] im_d [N_PTS];

    always_comb begin
        re_d = re_q;
        im_d = im_q;
        if (we) begin
            re_d[slot] = wr_r;
            im_d[slot] = wr_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_PTS; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else begin
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    assign rd_r = re_q;
    assign rd_i = im_q;

endmodule

// File: rtl/fft4_frame_loader.sv
// ---------------------------------------------------------------------------
// fft4_frame_loader
// Assembles a serial stream of complex samples into 4-sample frames held in
// a ping-pong pair of banks, presenting each completed frame in parallel
// (bit-reversed slot order when BIT_REVERSE = 1) to the FFT stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fft4_frame_loader_if
//                in_valid/in_ready/in_r/in_i/in_last : sample stream
//                out_valid/out_ready/out_r/out_i     : frame handshake
//                err_short / err_long                : framing error pulses
// ---------------------------------------------------------------------------
module fft4_frame_loader
    import fft_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft4_frame_loader_if.slave   bus
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_PTS - 1);

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [LOG2_N-1:0] wr_idx_q,  wr_idx_d;
    logic [1:0]        full_q,    full_d;
    logic              err_short_q, err_short_d;
    logic              err_long_q,  err_long_d;

    logic              accept;
    logic              consume;
    logic [LOG2_N-1:0] wr_slot;

    logic signed [DATA_W-1:0] bank_r [2][N_PTS];
    logic signed [DATA_W-1:0] bank_i [2][N_PTS];

    assign bus.in_ready  = !full_q[wr_bank_q];
    assign bus.out_valid = full_q[rd_bank_q];
    assign accept        = bus.in_valid && bus.in_ready;
    assign consume       = bus.out_valid && bus.out_ready;
    assign wr_slot       = BIT_REVERSE ? bitrev2(wr_idx_q) : wr_idx_q;

    // Completion and consumption always target different banks: a bank being
    // written is never full, while the bank being consumed always is. Both
    // updates can therefore be applied to full_d in the same cycle.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_idx_d    = wr_idx_q;
        full_d      = full_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;

        if (consume) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (accept) begin
            if (wr_idx_q == LAST_IDX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                wr_idx_d          = '0;
                err_long_d        = !bus.in_last;
            end else if (bus.in_last) begin
                // Early in_last: drop the partial frame; stale slots are
                // overwritten by the next frame before the bank is marked full.
                wr_idx_d    = '0;
                err_short_d = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            full_q      <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            full_q      <= full_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign bus.err_short = err_short_q;
    assign bus.err_long  = err_long_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft4_frame_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (accept && (wr_bank_q == 1'(b))),
            .slot  (wr_slot),
            .wr_r  (bus.in_r),
            .wr_i  (bus.in_i),
            .rd_r  (bank_r[b]),
            .rd_i  (bank_i[b])
        );
    end

    assign bus.out_r = bank_r[rd_bank_q];
    assign bus.out_i = bank_i[rd_bank_q];

endmodule

// File: tb/tb_fft4_frame_loader.sv
module tb_fft4_frame_loader;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fft4_frame_loader_if #(.DATA_W(8)) bus ();
    fft4_frame_loader_if #(.DATA_W(8)) bus_nat ();

    assign bus_nat.in_valid  = bus.in_valid;
    assign bus_nat.in_r      = bus.in_r;
    assign bus_nat.in_i      = bus.in_i;
    assign bus_nat.in_last   = bus.in_last;
    assign bus_nat.out_ready = bus.out_ready;

    fft4_frame_loader #(.DATA_W(8), .BIT_REVERSE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    fft4_frame_loader #(.DATA_W(8), .BIT_REVERSE(1'b0)) dut_nat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nat.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int br [4] = '{0, 2, 1, 3};

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int r, input int i, input logic last);
        bus.in_valid = 1'b1;
        bus.in_r     = 8'(r);
        bus.in_i     = 8'(i);
        bus.in_last  = last;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Frame of samples (base+n, -(base+n)), n = 0..3, seen in butterfly order.
    task automatic check_frame(input string tag, input int base);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_r%0d", tag, k), bus.out_r[k], base + br[k]);
            chk($sformatf("%s_i%0d", tag, k), bus.out_i[k], -(base + br[k]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_r%0d", tag, k), bus.out_r[k], 0);
            chk($sformatf("%s_i%0d", tag, k), bus.out_i[k], 0);
        end
    endtask

    task automatic send4(input int base, input logic last4);
        for (int n = 0; n < 4; n++) begin
            set_in(base + n, -(base + n), last4 && (n == 3));
            tick();
        end
        idle_in();
    endtask

    initial begin
        int acc;
        int frames;

        // Reset state
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_i      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_err_short", bus.err_short, 0);
        chk("rst_err_long", bus.err_long, 0);
        check_zero("rst_data");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single frame, bit-reversed and natural order
        bus.out_ready = 1'b1;
        send4(1, 1'b1);
        chk("f1_out_valid", bus.out_valid, 1);
        check_frame("f1", 1);
        chk("f1_err_long", bus.err_long, 0);
        chk("f1_err_short", bus.err_short, 0);
        chk("nat_out_valid", bus_nat.out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("nat_r%0d", k), bus_nat.out_r[k], k + 1);
            chk($sformatf("nat_i%0d", k), bus_nat.out_i[k], -(k + 1));
        end
        tick();
        chk("f1_valid_drop", bus.out_valid, 0);

        // Backpressure: 12 samples offered, both banks fill
        bus.out_ready = 1'b0;
        acc = 0;
        for (int j = 0; j < 12; j++) begin
            set_in(10 + j, -(10 + j), (j % 4) == 3);
            if (bus.in_ready) acc++;
            tick();
            if (j >= 3) begin
                chk("bp_valid", bus.out_valid, 1);
                check_frame("bp_hold", 10);
            end
        end
        idle_in();
        chk("bp_accepted", acc, 8);
        chk("bp_in_ready_low", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_in_ready_back", bus.in_ready, 1);
        chk("bp_f1_valid", bus.out_valid, 1);
        check_frame("bp_f1", 14);
        tick();
        chk("bp_drained", bus.out_valid, 0);

        // Streaming 64 samples, out_ready held high
        frames = 0;
        for (int n = 0; n < 64; n++) begin
            set_in(n - 32, 32 - n, (n % 4) == 3);
            chk("st_in_ready", bus.in_ready, 1);
            tick();
            if ((n % 4) == 3) begin
                chk("st_valid", bus.out_valid, 1);
                if (bus.out_valid) frames++;
                check_frame($sformatf("st%0d", n / 4), n - 3 - 32);
            end else begin
                chk("st_gap", bus.out_valid, 0);
            end
        end
        idle_in();
        chk("st_frames", frames, 16);

        // Short frame
        set_in(50, -50, 1'b0);
        tick();
        set_in(51, -51, 1'b1);
        tick();
        idle_in();
        chk("short_pulse", bus.err_short, 1);
        chk("short_no_frame", bus.out_valid, 0);
        tick();
        chk("short_pulse_end", bus.err_short, 0);
        chk("short_no_frame2", bus.out_valid, 0);
        send4(60, 1'b1);
        chk("after_short_valid", bus.out_valid, 1);
        check_frame("after_short", 60);
        chk("after_short_err", bus.err_short, 0);
        tick();

        // Long frame (no in_last on 4th sample)
        send4(70, 1'b0);
        chk("long_pulse", bus.err_long, 1);
        chk("long_valid", bus.out_valid, 1);
        check_frame("long", 70);
        tick();
        chk("long_pulse_end", bus.err_long, 0);
        chk("long_drained", bus.out_valid, 0);

        // Reset mid-frame with a frame pending
        bus.out_ready = 1'b0;
        send4(80, 1'b1);
        chk("mr_pending", bus.out_valid, 1);
        set_in(90, -90, 1'b0);
        tick();
        set_in(91, -91, 1'b0);
        tick();
        idle_in();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", bus.out_valid, 0);
        chk("mr_in_ready", bus.in_ready, 1);
        check_zero("mr_data");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        send4(100, 1'b1);
        chk("mr_frame_valid", bus.out_valid, 1);
        check_frame("mr_frame", 100);
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("mr_single_frame", bus.out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
